controlador_contador: RTL and testbench



---
 rtl/controlador_contador.sv | 111 +++++++++++
 tb/tb_controlador_contador.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/controlador_contador.sv
// Sequencing controller for the 4-bit arbitrary counter 0,3,5,6,9,10,12,15.
// Advances from a prescaler (RUN) or step edges (IDLE); loads via req/ack; repairs non-members.
module controlador_contador #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       step,
    input  logic       load_req,
    input  logic [3:0] load_val,
    output logic       load_ack,
    output logic [3:0] Q,
    output logic       valid,
    output logic       tick,
    output logic       wrap,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_e;

    localparam logic [3:0] PC_LAST = 4'(DIV - 1);

    function automatic logic is_member(input logic [3:0] v);
        case (v)
            4'd0, 4'd3, 4'd5, 4'd6, 4'd9, 4'd10, 4'd12, 4'd15: is_member = 1'b1;
            default:                                           is_member = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] succ(input logic [3:0] v);
        case (v)
            4'd0:    succ = 4'd3;
            4'd3:    succ = 4'd5;
            4'd5:    succ = 4'd6;
            4'd6:    succ = 4'd9;
            4'd9:    succ = 4'd10;
            4'd10:   succ = 4'd12;
            4'd12:   succ = 4'd15;
            default: succ = 4'd0;
        endcase
    endfunction

    // Non-members snap up to the next member; members map to themselves.
    function automatic logic [3:0] recov(input logic [3:0] v);
        case (v)
            4'd1, 4'd2:   recov = 4'd3;
            4'd4:         recov = 4'd5;
            4'd7, 4'd8:   recov = 4'd9;
            4'd11:        recov = 4'd12;
            4'd13, 4'd14: recov = 4'd15;
            default:      recov = v;
        endcase
    endfunction

    state_e     state_q;
    logic [3:0] q_q, pc_q, err_q;
    logic       step_q, ack_q, tick_q, wrap_q;

    logic load_acc, auto_adv, man_adv;

    assign load_acc = load_req && !ack_q && (state_q != RECOVER);
    assign auto_adv = (state_q == RUN) && (pc_q == PC_LAST);
    assign man_adv  = (state_q == IDLE) && !en && step && !step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= 4'd0;
            pc_q    <= 4'd0;
            err_q   <= 4'd0;
            step_q  <= 1'b0;
            ack_q   <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            step_q <= step;
            ack_q  <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (state_q == RECOVER) begin
                q_q     <= recov(q_q);
                pc_q    <= 4'd0;
                state_q <= en ? RUN : IDLE;
                if (err_q != 4'hF) err_q <= err_q + 4'd1;
            end else if (load_acc) begin
                // A load pre-empts any advance due this cycle; the lost advance is dropped.
                q_q     <= load_val;
                ack_q   <= 1'b1;
                pc_q    <= 4'd0;
                state_q <= is_member(load_val) ? (en ? RUN : IDLE) : RECOVER;
            end else begin
                if (auto_adv || man_adv) begin
                    q_q    <= succ(q_q);
                    wrap_q <= (q_q == 4'd15);
                end
                tick_q  <= auto_adv;
                pc_q    <= (state_q == RUN && en && !auto_adv) ? pc_q + 4'd1 : 4'd0;
                state_q <= en ? RUN : IDLE;
            end
        end
    end

    assign Q        = q_q;
    assign valid    = is_member(q_q);
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign load_ack = ack_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_controlador_contador.sv
// Scoreboard bench for controlador_contador: expectations queued per driven cycle, popped after each edge.
module tb_controlador_contador;

    logic       clk = 1'b0;
    logic       reset, en, step, load_req;
    logic [3:0] load_val;
    logic       load_ack, valid, tick, wrap;
    logic [3:0] Q, err_cnt;

    controlador_contador #(.DIV(4)) dut (
        .clk(clk), .reset(reset), .en(en), .step(step),
        .load_req(load_req), .load_val(load_val), .load_ack(load_ack),
        .Q(Q), .valid(valid), .tick(tick), .wrap(wrap), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       tick, wrap, ack;
        logic [3:0] err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [3:0] e_err;
    logic [3:0] seq [8] = '{4'd0, 4'd3, 4'd5, 4'd6, 4'd9, 4'd10, 4'd12, 4'd15};

    function automatic logic member(input logic [3:0] v);
        return v inside {4'd0, 4'd3, 4'd5, 4'd6, 4'd9, 4'd10, 4'd12, 4'd15};
    endfunction

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] q, input logic t, input logic w,
                        input logic a, input logic [3:0] e);
        exp_t x;
        x.tag = tag; x.q = q; x.tick = t; x.wrap = w; x.ack = a; x.err = e;
        sb.push_back(x);
    endtask

    // Advance one edge, then compare every output against the oldest expectation.
    task automatic cyc();
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 8'd0, 8'd1);
        end else begin
            x = sb.pop_front();
            check({x.tag, ".Q"},     {4'd0, Q},       {4'd0, x.q});
            check({x.tag, ".valid"}, {7'd0, valid},   {7'd0, member(x.q)});
            check({x.tag, ".tick"},  {7'd0, tick},    {7'd0, x.tick});
            check({x.tag, ".wrap"},  {7'd0, wrap},    {7'd0, x.wrap});
            check({x.tag, ".ack"},   {7'd0, load_ack},{7'd0, x.ack});
            check({x.tag, ".err"},   {4'd0, err_cnt}, {4'd0, x.err});
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; step = 1'b0; load_req = 1'b0; load_val = 4'd0;
        e_err = 4'd0;

        for (int i = 0; i < 2; i++) begin push("rst", 4'd0, 0, 0, 0, 4'd0); cyc(); end
        reset = 1'b0;

        // Automatic run: one advance every 4 edges after the RUN-entry edge.
        en = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            int  k;
            logic t;
            k = (i - 1) / 4;
            t = (i > 1) && ((i - 1) % 4 == 0);
            push("run", seq[k % 8], t, t && (k == 8), 0, 4'd0);
            cyc();
        end

        // Reset from mid-RUN, held two cycles.
        reset = 1'b1;
        push("rst_run", 4'd0, 0, 0, 0, 4'd0); cyc();
        en = 1'b0;
        push("rst_run2", 4'd0, 0, 0, 0, 4'd0); cyc();
        reset = 1'b0;

        // Illegal load of 7 in IDLE: shows 7, then recovers to 9.
        load_req = 1'b1; load_val = 4'd7;
        push("ill_load", 4'd7, 0, 0, 1, 4'd0); cyc();
        load_req = 1'b0;
        e_err = 4'd1;
        push("ill_recov", 4'd9, 0, 0, 0, e_err); cyc();
        push("ill_hold", 4'd9, 0, 0, 0, e_err); cyc();

        // Manual step from 12: held step advances once; second pulse wraps.
        load_req = 1'b1; load_val = 4'd12;
        push("man_load", 4'd12, 0, 0, 1, e_err); cyc();
        load_req = 1'b0;
        push("man_idle", 4'd12, 0, 0, 0, e_err); cyc();
        step = 1'b1;
        push("man_step1", 4'd15, 0, 0, 0, e_err); cyc();
        push("man_held", 4'd15, 0, 0, 0, e_err); cyc();
        push("man_held", 4'd15, 0, 0, 0, e_err); cyc();
        step = 1'b0;
        push("man_low", 4'd15, 0, 0, 0, e_err); cyc();
        step = 1'b1;
        push("man_wrap", 4'd0, 0, 1, 0, e_err); cyc();
        step = 1'b0;
        push("man_after", 4'd0, 0, 0, 0, e_err); cyc();

        // Load on the pc==DIV-1 cycle beats the tick; next tick a full period later.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin push("col_pre", 4'd0, 0, 0, 0, e_err); cyc(); end
        load_req = 1'b1; load_val = 4'd5;
        push("col_load", 4'd5, 0, 0, 1, e_err); cyc();
        load_req = 1'b0;
        for (int i = 0; i < 3; i++) begin push("col_wait", 4'd5, 0, 0, 0, e_err); cyc(); end
        push("col_tick", 4'd6, 1, 0, 0, e_err); cyc();
        load_req = 1'b1;
        push("held_a1", 4'd5, 0, 0, 1, e_err); cyc();
        push("held_a0", 4'd5, 0, 0, 0, e_err); cyc();
        push("held_a1b", 4'd5, 0, 0, 1, e_err); cyc();
        load_req = 1'b0;
        push("held_end", 4'd5, 0, 0, 0, e_err); cyc();
        en = 1'b0;
        push("to_idle", 4'd5, 0, 0, 0, e_err); cyc();

        // Saturation: 17 illegal loads of 14 from a cleared error count.
        reset = 1'b1;
        push("rst_sat", 4'd0, 0, 0, 0, 4'd0); cyc();
        reset = 1'b0;
        e_err = 4'd0;
        for (int k = 0; k < 17; k++) begin
            load_req = 1'b1; load_val = 4'd14;
            push("sat_load", 4'd14, 0, 0, 1, e_err); cyc();
            load_req = 1'b0;
            if (e_err != 4'hF) e_err = e_err + 4'd1;
            push("sat_recov", 4'd15, 0, 0, 0, e_err); cyc();
        end

        // Reset mid-period with en held high, then a fresh full period.
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin push("mid_run", 4'd15, 0, 0, 0, 4'd15); cyc(); end
        reset = 1'b1;
        push("mid_rst", 4'd0, 0, 0, 0, 4'd0); cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin push("post_rst", 4'd0, 0, 0, 0, 4'd0); cyc(); end
        push("post_tick", 4'd3, 1, 0, 0, 4'd0); cyc();

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
